gated_fu_ctrl: RTL
==================

# gated_fu_ctrl

Job sequencer for the precision-scalable `gated_fu` multiplier. It accepts a dot-product job (mode, beat count) and streams operand pairs through `gated_fu`. It reduces the packed sub-word products of each beat to one lane sum and accumulates the sums into a single result. It sits between the PE operand buffers and the output writeback, and owns the only `gated_fu` instance in the PE.

## Interface
Parameters:
- `ACC_W`, 32, accumulator/result width (≥16)
- `LEN_W`, 8, width of job beat count

Ports:
- `clk`  in  1  clock, rising edge
- `nrst`  in  1  asynchronous active-low reset
- `job_valid`  in  1  job request
- `job_ready`  out  1  high only in IDLE
- `job_mode`  in  2  00 = 8x8, 01 = 2×4x4, 10 = 4×2x2, 11 = treated as 00
- `job_len`  in  LEN_W  number of operand beats; 0 is legal
- `op_valid`  in  1  operand beat valid
- `op_ready`  out  1  high only in RUN
- `op_a`, `op_b`  in  8 each  operand bytes, unsigned
- `res_valid`  out  1  result valid
- `res_ready`  in  1  result accepted
- `res_data`  out  ACC_W  accumulated sum
- `res_ovf`  out  1  accumulator saturated (see Configuration)
- `busy`  out  1  state ≠ IDLE

## Operation
- **FSM states:** IDLE, RUN, DRAIN, DONE.
- **IDLE**
  - On job handshake, latch mode and len, clear the accumulator and `res_ovf`, and zero the beat counter.
  - If len == 0, go to DONE. Otherwise go to RUN.
- **RUN**
  - Each `op_valid && op_ready` beat loads `op_a`/`op_b` into stage-1 registers (s1 valid bit set) and increments the counter.
  - On the beat where counter == len−1, go to DRAIN.
  - An `op_valid` gap inserts a bubble (s1 valid = 0). There is no stall inside the pipe.
- **DRAIN:** `op_ready` = 0. When s1 and s2 valid bits are both clear after the update, go to DONE.
- **DONE:** `res_valid` = 1, with `res_data` and `res_ovf` held stable. On `res_ready`, go to IDLE.
- **Pipe stages**
  - s1: operand registers feed `gated_fu` combinationally with the latched mode.
  - s2: the lane sum is registered.
  - Accumulate: acc += zero-extended lane sum when s2 is valid.
- **`gated_fu` output packing**
  - Mode 00: `p` = a·b.
  - Mode 01: `p[7:0]` = a[3:0]·b[3:0] and `p[15:8]` = a[7:4]·b[7:4].
  - Mode 10: `p[4i+3:4i]` = a[2i+1:2i]·b[2i+1:2i], for i = 0..3.
- **Lane sum**
  - Mode 00: `p`.
  - Mode 01: `p[15:8]` + `p[7:0]` (≤ 450).
  - Mode 10: sum of the four nibbles (≤ 36).
  - The lane sum is 16 bits wide in all modes.
- **Reset mid-operation:** asserting `nrst` at any time forces IDLE and clears all pipe valid bits, the accumulator and the counter. It aborts any in-flight job with no result.
- **Mode change:** `job_mode` is sampled only at the job handshake. Changes during a job are ignored.

## Timing
- **Reset values:** `job_ready` = 1, `op_ready` = 0, `res_valid` = 0, `res_data` = 0, `res_ovf` = 0, `busy` = 0.
- **Final-beat latency:** if the final beat is accepted at edge k, s2 loads at k+1, the accumulator is final at k+2, and `res_valid` is high from k+2.
- **len == 0:** `res_valid` is high from the edge after the job handshake, with `res_data` = 0.
- **Job overlap:** `job_ready` is low from the job handshake until the result is accepted, so jobs never overlap.
- **Throughput:** one beat per cycle in RUN.
- **Result hold:** `res_data` must not change while `res_valid && !res_ready`.

## Configuration
- **Macro:** `GATED_FU_CTRL_SAT_EN`.
- **Defined:** an accumulate that would exceed 2^ACC_W−1 clamps to 2^ACC_W−1. `res_ovf` is set and stays sticky until the next job handshake.
- **Undefined:** the accumulator wraps modulo 2^ACC_W and `res_ovf` is tied 0.

## Structure
- **Shared package `gated_fu_pkg`:**
  - Mode encodings `MODE_8X8`, `MODE_4X4`, `MODE_2X2`.
  - FSM state typedef (IDLE/RUN/DRAIN/DONE).
  - Lane-sum width constant (16).
- **Sub-modules:**
  - One new sub-module, `fu_lane_sum`: combinational reduction of `p` by mode.
  - The existing `gated_fu` is instantiated as-is.

## Test plan
- **4x4 single beat:** mode 01, len 1, a=0x11, b=0x23 → `res_data` = 5 (3+2), with `res_valid` 2 edges after the beat.
- **8x8 multi-beat:** mode 00, len 3, a=15, b=3 every beat, with one `op_valid` gap → `res_data` = 135 and exactly 3 beats consumed.
- **2x2 maximum:** mode 10, len 2, a=b=0xFF → each beat gives 4 lanes × 9 = 36, so `res_data` = 72.
- **Zero length:** len 0 → `res_valid` on the next edge, `res_data` = 0, `op_ready` never high.
- **Overflow:** `ACC_W` = 16, mode 00, len 2, a=b=255.
  - With the macro: `res_data` = 65535 and `res_ovf` = 1.
  - Without the macro: `res_data` = 64514 and `res_ovf` = 0.
- **Backpressure and reset:**
  - Hold `res_ready` low 5 cycles → `res_data` is stable and `job_ready` stays low.
  - Pulse `nrst` mid-RUN → all outputs return to reset values. A following len-1 job of 2×2 (mode 00) gives 4.

Source files
------------

// File: rtl/gated_fu_pkg.sv
// Shared definitions for the gated_fu multiplier and its job sequencer.
// Covers the mode encodings, the sequencer state type and the lane-sum width.
package gated_fu_pkg;

    localparam logic [1:0] MODE_8X8 = 2'b00;
    localparam logic [1:0] MODE_4X4 = 2'b01;
    localparam logic [1:0] MODE_2X2 = 2'b10;

    localparam int LANE_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_DRAIN = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

endpackage

// File: rtl/gated_fu_ctrl_if.sv
// Job, operand and result handshakes between the PE buffers/writeback and gated_fu_ctrl.
interface gated_fu_ctrl_if #(
    parameter int ACC_W = 32,
    parameter int LEN_W = 8
);
    logic             job_valid;
    logic             job_ready;
    logic [1:0]       job_mode;
    logic [LEN_W-1:0] job_len;
    logic             op_valid;
    logic             op_ready;
    logic [7:0]       op_a;
    logic [7:0]       op_b;
    logic             res_valid;
    logic             res_ready;
    logic [ACC_W-1:0] res_data;
    logic             res_ovf;
    logic             busy;

    modport master (
        output job_valid, job_mode, job_len, op_valid, op_a, op_b, res_ready,
        input  job_ready, op_ready, res_valid, res_data, res_ovf, busy
    );

    modport slave (
        input  job_valid, job_mode, job_len, op_valid, op_a, op_b, res_ready,
        output job_ready, op_ready, res_valid, res_data, res_ovf, busy
    );
endinterface

// File: rtl/fu_lane_sum.sv
// Reduces the packed sub-word products of gated_fu to a single lane sum.
module fu_lane_sum
    import gated_fu_pkg::*;
(
    input  logic [1:0]        mode,
    input  logic [15:0]       p,
    output logic [LANE_W-1:0] sum
);

    always_comb begin
        sum = '0;
        case (mode)
            MODE_4X4: sum = {8'b0, p[15:8]} + {8'b0, p[7:0]};
            MODE_2X2: sum = {12'b0, p[15:12]} + {12'b0, p[11:8]}
                          + {12'b0, p[7:4]}   + {12'b0, p[3:0]};
            default:  sum = p;
        endcase
    end

endmodule

// File: rtl/gated_fu.sv
// Precision-scalable unsigned multiplier: one 8x8, two 4x4 or four 2x2 products
// packed into a 16-bit result. Mode 11 behaves as 8x8.
module gated_fu
    import gated_fu_pkg::*;
(
    input  logic [1:0]  mode,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] p
);

    always_comb begin
        p = '0;
        case (mode)
            MODE_4X4: begin
                p[7:0]  = {4'b0, a[3:0]} * {4'b0, b[3:0]};
                p[15:8] = {4'b0, a[7:4]} * {4'b0, b[7:4]};
            end
            MODE_2X2: begin
                for (int i = 0; i < 4; i++) begin
                    p[4*i +: 4] = {2'b0, a[2*i +: 2]} * {2'b0, b[2*i +: 2]};
                end
            end
            default: p = {8'b0, a} * {8'b0, b};
        endcase
    end

endmodule

// File: rtl/gated_fu_ctrl.sv
// Dot-product job sequencer around gated_fu: operand pipe, lane reduction, accumulate.
// GATED_FU_CTRL_SAT_EN selects a saturating accumulator with sticky res_ovf.
//
// state    | meaning
// ---------+---------------------------------------------------
// ST_IDLE  | waiting for a job; job_ready high
// ST_RUN   | accepting operand beats; op_ready high
// ST_DRAIN | final beat accepted; flushing s1/s2 into the acc
// ST_DONE  | result presented until res_ready
module gated_fu_ctrl
    import gated_fu_pkg::*;
#(
    parameter int ACC_W = 32,
    parameter int LEN_W = 8
)(
    input  logic           clk,
    input  logic           nrst,
    gated_fu_ctrl_if.slave bus
);

    state_e            state;
    logic [1:0]        mode_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  cnt;
    logic              s1_v;
    logic [7:0]        s1_a;
    logic [7:0]        s1_b;
    logic              s2_v;
    logic [LANE_W-1:0] s2_sum;
    logic [ACC_W-1:0]  acc;
    logic              job_ready_q;
    logic              op_ready_q;
    logic              res_valid_q;
    logic              busy_q;

    logic [15:0]       prod;
    logic [LANE_W-1:0] lane_sum;
    logic              beat;

    assign beat = bus.op_valid && op_ready_q;

    gated_fu u_fu (
        .mode (mode_q),
        .a    (s1_a),
        .b    (s1_b),
        .p    (prod)
    );

    fu_lane_sum u_lane_sum (
        .mode (mode_q),
        .p    (prod),
        .sum  (lane_sum)
    );

`ifdef GATED_FU_CTRL_SAT_EN
    logic             ovf_q;
    logic [ACC_W:0]   acc_sum;
    assign acc_sum = {1'b0, acc} + (ACC_W+1)'(s2_sum);
    assign bus.res_ovf = ovf_q;
`else
    logic [ACC_W-1:0] acc_sum;
    assign acc_sum = acc + ACC_W'(s2_sum);
    assign bus.res_ovf = 1'b0;
`endif

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state       <= ST_IDLE;
            mode_q      <= MODE_8X8;
            len_q       <= '0;
            cnt         <= '0;
            s1_v        <= 1'b0;
            s1_a        <= '0;
            s1_b        <= '0;
            s2_v        <= 1'b0;
            s2_sum      <= '0;
            acc         <= '0;
            job_ready_q <= 1'b1;
            op_ready_q  <= 1'b0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef GATED_FU_CTRL_SAT_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            s1_v <= beat;
            if (beat) begin
                s1_a <= bus.op_a;
                s1_b <= bus.op_b;
            end
            s2_v <= s1_v;
            if (s1_v) s2_sum <= lane_sum;

            if (s2_v) begin
`ifdef GATED_FU_CTRL_SAT_EN
                if (acc_sum[ACC_W]) begin
                    acc   <= '1;
                    ovf_q <= 1'b1;
                end else begin
                    acc <= acc_sum[ACC_W-1:0];
                end
`else
                acc <= acc_sum;
`endif
            end

            case (state)
                ST_IDLE: begin
                    if (bus.job_valid) begin
                        mode_q      <= bus.job_mode;
                        len_q       <= bus.job_len;
                        cnt         <= '0;
                        acc         <= '0;
`ifdef GATED_FU_CTRL_SAT_EN
                        ovf_q       <= 1'b0;
`endif
                        job_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        if (bus.job_len == '0) begin
                            state       <= ST_DONE;
                            res_valid_q <= 1'b1;
                        end else begin
                            state      <= ST_RUN;
                            op_ready_q <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (beat) begin
                        cnt <= cnt + LEN_W'(1);
                        if (cnt == len_q - LEN_W'(1)) begin
                            state      <= ST_DRAIN;
                            op_ready_q <= 1'b0;
                        end
                    end
                end
                ST_DRAIN: begin
                    // s1 empties this edge; s2 empties on this edge only if s1 already was empty
                    if (!s1_v) begin
                        state       <= ST_DONE;
                        res_valid_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (bus.res_ready) begin
                        state       <= ST_IDLE;
                        res_valid_q <= 1'b0;
                        job_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.job_ready = job_ready_q;
    assign bus.op_ready  = op_ready_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = acc;
    assign bus.busy      = busy_q;

endmodule
